// File: rtl/cbus_ram_responder.sv
// CBus RAM responder: word-addressed memory answering single and INCR burst
// requests, with tunable first-beat latency and inter-beat gap.
package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_ram_responder
  import cbus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned BEAT_GAP   = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  req,
  output cbus_resp_t resp,
  output logic       busy
);
  localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [15:0] LAT_END = 16'((LATENCY  == 0) ? 0 : LATENCY  - 1);
  localparam logic [15:0] GAP_END = 16'((BEAT_GAP == 0) ? 0 : BEAT_GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_GAP} state_t;

  state_t                r_state;
  logic                  r_is_write;
  logic [3:0]            r_len;
  logic [3:0]            r_beat;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [15:0]           r_cnt;
  logic [31:0]           r_mem [DEPTH];

  logic w_beat;
  logic w_last;
  logic w_we;
  logic w_unused;

  // A dropped valid aborts the burst: no last and no write in that cycle.
  assign w_beat   = (r_state == S_BEAT);
  assign w_last   = w_beat && req.valid && (r_beat == r_len);
  assign w_we     = w_beat && req.valid && r_is_write && resetn;
  assign busy     = (r_state != S_IDLE);
  assign w_unused = ^{req.size, req.addr[31:ADDR_WIDTH+2], req.addr[1:0]};

  always_comb begin
    resp       = '0;
    resp.ready = w_beat;
    resp.last  = w_last;
    resp.data  = (w_beat && !r_is_write) ? r_mem[r_ptr] : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_is_write <= 1'b0;
      r_len      <= 4'd0;
      r_beat     <= 4'd0;
      r_ptr      <= '0;
      r_cnt      <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req.valid) begin
            r_is_write <= req.is_write;
            r_len      <= req.len;
            r_ptr      <= req.addr[ADDR_WIDTH+1:2];
            r_beat     <= 4'd0;
            r_cnt      <= 16'd0;
            r_state    <= (LATENCY > 0) ? S_WAIT : S_BEAT;
          end
        end
        S_WAIT: begin
          if (!req.valid) begin
            r_state <= S_IDLE;
          end else if (r_cnt == LAT_END) begin
            r_cnt   <= 16'd0;
            r_state <= S_BEAT;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_BEAT: begin
          if (!req.valid) begin
            r_state <= S_IDLE;
          end else begin
            r_ptr  <= r_ptr + 1'b1;
            r_beat <= r_beat + 4'd1;
            r_cnt  <= 16'd0;
            if (r_beat == r_len) begin
              r_state <= S_IDLE;
            end else if (BEAT_GAP > 0) begin
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (!req.valid) begin
            r_state <= S_IDLE;
          end else if (r_cnt == GAP_END) begin
            r_cnt   <= 16'd0;
            r_state <= S_BEAT;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage is deliberately outside reset so contents survive resetn.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (req.strobe[i]) begin
          r_mem[r_ptr][8*i +: 8] <= req.data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_cbus_ram_responder.sv
// Bench for cbus_ram_responder: two instances (large/no-gap and tiny/gapped)
// driven by directed and random bursts, checked against an array model.
module tb_cbus_ram_responder;
  import cbus_pkg::*;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       resetnA;
  logic       resetnB;
  cbus_req_t  reqA;
  cbus_req_t  reqB;
  cbus_resp_t respA;
  cbus_resp_t respB;
  logic       busyA;
  logic       busyB;

  int vecCount = 0;
  int errCount = 0;

  logic [31:0] memA [4096];
  bit          wrA  [4096];
  logic [31:0] memB [16];
  bit          wrB  [16];
  logic [31:0] txData [16];
  logic [3:0]  txStrb [16];
  logic [31:0] lastRead;
  int          lens [5] = '{0, 1, 3, 7, 15};

  always #5 clk = ~clk;

  cbus_ram_responder #(.ADDR_WIDTH(12), .LATENCY(LAT), .BEAT_GAP(0)) dutA (
    .clk(clk), .resetn(resetnA), .req(reqA), .resp(respA), .busy(busyA)
  );

  cbus_ram_responder #(.ADDR_WIDTH(4), .LATENCY(LAT), .BEAT_GAP(1)) dutB (
    .clk(clk), .resetn(resetnB), .req(reqB), .resp(respB), .busy(busyB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic driveReq(input int dut, input cbus_req_t r);
    if (dut == 0) reqA = r;
    else reqB = r;
  endtask

  task automatic setReset(input int dut, input logic v);
    if (dut == 0) resetnA = v;
    else resetnB = v;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  // One transaction; abortBeat/resetBeat name the beat index whose cycle
  // drops valid or asserts reset (-1 for none).
  task automatic applyStimulus(input int dut, input bit wr, input int word, input int len,
                               input int abortBeat, input int resetBeat);
    int        gap = (dut == 1) ? 1 : 0;
    int        aw = (dut == 1) ? 4 : 12;
    int        mask = (1 << aw) - 1;
    int        lastCycle = LAT + 1 + len * (gap + 1);
    bit        stop = 0;
    cbus_req_t r;
    cbus_resp_t rs;
    logic      bz;
    string     pfx;
    pfx = (dut == 1) ? "B" : "A";
    r.valid    = 1'b1;
    r.is_write = wr;
    r.size     = 3'($urandom);
    r.addr     = (32'($urandom) << (aw + 2)) | 32'(word << 2) | 32'($urandom_range(0, 3));
    r.strobe   = 4'($urandom);
    r.data     = $urandom;
    r.len      = 4'(len);
    for (int c = 0; c <= lastCycle && !stop; c++) begin
      bit isBeat;
      int k;
      int idx;
      bit known;
      logic [31:0] model;
      isBeat = (c >= LAT + 1) && (((c - LAT - 1) % (gap + 1)) == 0);
      k = isBeat ? (c - LAT - 1) / (gap + 1) : -1;
      idx = (word + ((k < 0) ? 0 : k)) & mask;
      if (c > 0) begin
        r.addr     = $urandom;
        r.len      = 4'($urandom);
        r.is_write = 1'($urandom);
        r.size     = 3'($urandom);
      end
      if (isBeat) begin
        r.data   = txData[k];
        r.strobe = txStrb[k];
      end else begin
        r.data   = $urandom;
        r.strobe = 4'($urandom);
      end
      if (isBeat && k == abortBeat) r.valid = 1'b0;
      driveReq(dut, r);
      if (isBeat && k == resetBeat) setReset(dut, 1'b0);
      @(negedge clk);
      rs = (dut == 0) ? respA : respB;
      bz = (dut == 0) ? busyA : busyB;
      known = (dut == 0) ? wrA[idx] : wrB[idx];
      model = (dut == 0) ? memA[idx] : memB[idx];
      checkOutput($sformatf("%s busy c%0d", pfx, c), 32'(bz), 32'(c >= 1));
      checkOutput($sformatf("%s last c%0d", pfx, c), 32'(rs.last),
                  32'(isBeat && k == len && k != abortBeat));
      if (!(isBeat && k == abortBeat)) begin
        checkOutput($sformatf("%s ready c%0d", pfx, c), 32'(rs.ready), 32'(isBeat));
        if (!(isBeat && !wr)) checkOutput($sformatf("%s zdata c%0d", pfx, c), rs.data, 32'h0);
        else if (known) checkOutput($sformatf("%s rdata c%0d", pfx, c), rs.data, model);
      end
      if (isBeat && !wr) lastRead = rs.data;
      if (isBeat && wr && k != abortBeat && k != resetBeat) begin
        if (dut == 0) begin
          memA[idx] = merge(memA[idx], txData[k], txStrb[k]);
          if (txStrb[k] == 4'hF) wrA[idx] = 1'b1;
        end else begin
          memB[idx] = merge(memB[idx], txData[k], txStrb[k]);
          if (txStrb[k] == 4'hF) wrB[idx] = 1'b1;
        end
      end
      if (isBeat && (k == abortBeat || k == resetBeat)) stop = 1;
      @(posedge clk);
      #1;
    end
    r.valid = 1'b0;
    driveReq(dut, r);
    setReset(dut, 1'b1);
    @(negedge clk);
    rs = (dut == 0) ? respA : respB;
    bz = (dut == 0) ? busyA : busyB;
    checkOutput($sformatf("%s idle busy", pfx), 32'(bz), 32'h0);
    checkOutput($sformatf("%s idle ready", pfx), 32'(rs.ready), 32'h0);
    checkOutput($sformatf("%s idle data", pfx), rs.data, 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reqA = '0;
    reqB = '0;
    resetnA = 1'b0;
    resetnB = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("rst A resp", 32'({respA.ready, respA.last, busyA}), 32'h0);
      checkOutput("rst A data", respA.data, 32'h0);
      checkOutput("rst B resp", 32'({respB.ready, respB.last, busyB}), 32'h0);
      checkOutput("rst B data", respB.data, 32'h0);
      @(posedge clk);
      #1;
    end
    resetnA = 1'b1;
    resetnB = 1'b1;

    txData[0] = 32'hDEADBEEF; txStrb[0] = 4'hF;
    applyStimulus(0, 1, 'h10, 0, -1, -1);
    applyStimulus(0, 0, 'h10, 0, -1, -1);
    checkOutput("read 0x40", lastRead, 32'hDEADBEEF);

    txData[0] = 32'h11223344; txStrb[0] = 4'hF;
    applyStimulus(0, 1, 'h4, 0, -1, -1);
    txData[0] = 32'hAABBCCDD; txStrb[0] = 4'h5;
    applyStimulus(0, 1, 'h4, 0, -1, -1);
    applyStimulus(0, 0, 'h4, 0, -1, -1);
    checkOutput("partial strobe", lastRead, 32'h11BB33DD);

    for (int k = 0; k < 16; k++) begin
      txData[k] = 32'(k);
      txStrb[k] = 4'hF;
    end
    applyStimulus(0, 1, 'h40, 15, -1, -1);
    applyStimulus(0, 0, 'h40, 15, -1, -1);
    checkOutput("burst last word", lastRead, 32'd15);

    for (int k = 0; k < 4; k++) txData[k] = 32'hB0 + 32'(k);
    applyStimulus(1, 1, 14, 3, -1, -1);
    applyStimulus(1, 0, 14, 3, -1, -1);
    applyStimulus(1, 0, 1, 0, -1, -1);
    checkOutput("wrap word1", lastRead, 32'hB3);

    for (int k = 0; k < 8; k++) begin
      txData[k] = 32'h1000 + 32'(k);
      txStrb[k] = 4'hF;
    end
    applyStimulus(0, 1, 'h140, 7, -1, -1);
    for (int k = 0; k < 8; k++) txData[k] = 32'h2000 + 32'(k);
    applyStimulus(0, 1, 'h140, 7, 2, -1);
    applyStimulus(0, 0, 'h140, 7, -1, -1);
    checkOutput("abort word7", lastRead, 32'h1007);
    for (int k = 0; k < 8; k++) txData[k] = 32'h3000 + 32'(k);
    applyStimulus(0, 1, 'h140, 7, -1, 3);
    applyStimulus(0, 0, 'h142, 0, -1, -1);
    checkOutput("reset word2", lastRead, 32'h3002);
    applyStimulus(0, 0, 'h143, 0, -1, -1);
    checkOutput("reset word3", lastRead, 32'h1003);

    for (int n = 0; n < 24; n++) begin
      for (int k = 0; k < 16; k++) begin
        txData[k] = $urandom;
        txStrb[k] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      end
      applyStimulus(0, 1'($urandom), 'h300 + $urandom_range(0, 31), lens[$urandom_range(0, 4)], -1, -1);
    end
    for (int n = 0; n < 12; n++) begin
      for (int k = 0; k < 16; k++) begin
        txData[k] = $urandom;
        txStrb[k] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      end
      applyStimulus(1, 1'($urandom), $urandom_range(0, 15), lens[$urandom_range(0, 4)], -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
